// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: instruction + PC with valid/ready handshake,
// optional 2-entry skid buffer, stall, flush, NOP bubbles and a bubble counter.
module pipe_stage_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_VALUE = '0,
  parameter bit                 SKID_EN   = 1'b1,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               flush_i,
  input  logic               stall_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [1:0]         occupancy_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               out_valid_q, skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
  logic               fire_in, fire_out;

  // With the skid buffer, readiness depends only on flops, which breaks the
  // combinational ready chain between neighbouring stages.
  assign in_ready_o = SKID_EN ? ~skid_valid_q
                              : (~out_valid_q | (out_ready_i & ~stall_i));
  assign fire_out   = out_valid_q & out_ready_i & ~stall_i;
  assign fire_in    = in_valid_i & in_ready_o;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    bubble_cnt_d = bubble_cnt_q;

    if (start_i && !out_valid_q && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);

    if (!start_i) begin
      state_d      = EMPTY;
      skid_valid_d = 1'b0;
      main_instr_d = NOP_VALUE;
      main_pc_d    = '0;
    end else if (flush_i) begin
      // PC keeps tracking the upstream stage while the bubble passes through.
      state_d      = EMPTY;
      skid_valid_d = 1'b0;
      main_instr_d = NOP_VALUE;
      main_pc_d    = pc_i;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (fire_in) begin
            state_d      = ONE;
            main_instr_d = instr_i;
            main_pc_d    = pc_i;
          end
        end
        ONE: begin
          if (fire_in && fire_out) begin
            main_instr_d = instr_i;
            main_pc_d    = pc_i;
          end else if (fire_in && SKID_EN) begin
            state_d      = FULL;
            skid_valid_d = 1'b1;
            skid_instr_d = instr_i;
            skid_pc_d    = pc_i;
          end else if (fire_out) begin
            state_d      = EMPTY;
            main_instr_d = NOP_VALUE;
          end
        end
        FULL: begin
          if (fire_out) begin
            state_d      = ONE;
            skid_valid_d = 1'b0;
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
          end
        end
        default: begin
          state_d      = EMPTY;
          skid_valid_d = 1'b0;
          main_instr_d = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= EMPTY;
      out_valid_q  <= 1'b0;
      main_instr_q <= NOP_VALUE;
      main_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= (state_d != EMPTY);
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign instr_o      = main_instr_q;
  assign pc_o         = main_pc_q;
  assign occupancy_o  = state_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised successor to the fixed 32-bit IF/ID stage register. It is a generic pipeline-stage register carrying an instruction word and PC, with a valid/ready handshake, an optional 2-entry skid buffer, stall and flush, and NOP-bubble insertion. It sits between any two pipeline stages (IF/ID, ID/EX, ...). It also provides a saturating bubble counter for performance monitoring.

Parameters:
INSTR_W, 32, instruction field width
PC_W, 32, PC field width
NOP_VALUE, {INSTR_W{1'b0}}, instruction word driven whenever the stage holds no valid entry
SKID_EN, 1, 1 = 2-entry skid (in_ready_o registered); 0 = single entry (in_ready_o combinational)
CNT_W, 16, bubble counter width

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
start_i  input  1  synchronous run enable; low = clear stage
flush_i  input  1  synchronous flush; discards all held entries
stall_i  input  1  hazard stall; blocks output transfer
in_valid_i  input  1  upstream entry valid
in_ready_o  output  1  stage can accept an entry
instr_i  input  INSTR_W  upstream instruction
pc_i  input  PC_W  upstream PC
out_valid_o  output  1  output entry valid
out_ready_i  input  1  downstream accepts
instr_o  output  INSTR_W  output instruction (NOP_VALUE when not valid)
pc_o  output  PC_W  output PC
occupancy_o  output  2  entries held (0..2)
bubble_cnt_o  output  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset (rst_n_i low, async): out_valid_o=0, skid invalid, instr_o=NOP_VALUE, pc_o=0, occupancy_o=0, bubble_cnt_o=0. in_ready_o=1 after reset.
- Priority, highest first: rst_n_i > ~start_i > flush_i > normal operation.
- start_i low: same clear as reset, applied at the clock edge. bubble_cnt_o holds its value.
- fire_out = out_valid_o & out_ready_i & ~stall_i. fire_in = in_valid_i & in_ready_o.
- SKID_EN=1: in_ready_o = ~skid_valid (registered). States:
  EMPTY (occ 0): fire_in -> ONE, main<=input.
  ONE (occ 1): fire_in & fire_out -> ONE, main<=input. fire_in & ~fire_out -> FULL, skid<=input. ~fire_in & fire_out -> EMPTY. Otherwise hold.
  FULL (occ 2): in_ready_o=0. fire_out -> ONE, main<=skid. Otherwise hold.
- SKID_EN=0: in_ready_o = ~out_valid_o | (out_ready_i & ~stall_i), combinational. Only states EMPTY and ONE exist; occupancy_o never exceeds 1.
- Latency: an accepted entry appears on the outputs one cycle after fire_in when the stage was EMPTY or ONE-with-fire_out.
- Stall: main and skid hold; instr_o and pc_o are unchanged. An entry may still be accepted into skid when in ONE.
- Flush (start_i=1):
  - Next edge: out_valid_o=0, skid invalid, instr_o=NOP_VALUE, occupancy_o=0.
  - pc_o<=pc_i, so PC tracking continues through the bubble.
  - A simultaneous fire_in is dropped. The upstream stage is flushed by the same hazard unit.
  - Flush overrides stall.
- Bubble: whenever an edge leaves main invalid, instr_o=NOP_VALUE. Upon ONE->EMPTY, pc_o holds its last value.
- bubble_cnt_o: increments each cycle where start_i=1 and out_valid_o=0. Saturates at all-ones, with no wrap.
- Outputs instr_o, pc_o, out_valid_o and occupancy_o are registered. in_ready_o is registered when SKID_EN=1.
- in_valid_i low with garbage data: no state change. Data inputs are sampled only on fire_in.

Test Plan:
- Reset mid-stream: FULL with instr 0xA1/0xA2, assert rst_n_i low between edges -> out_valid_o=0, instr_o=0, pc_o=0, occupancy_o=0 immediately, without waiting for a clock.
- Streaming: out_ready_i=1, stall_i=0; 8 entries instr=0x100+k, pc=4k on consecutive cycles -> outputs appear 1 cycle later in order, occupancy_o=1 throughout, no bubbles counted after the first.
- Backpressure (SKID_EN=1): load 0x11, then out_ready_i=0 while sending 0x22 -> occupancy_o=2, in_ready_o=0. Release -> 0x11 then 0x22 delivered, with nothing lost or duplicated.
- Stall vs flush: ONE with 0x33 at pc 0x40, stall_i=1 for 3 cycles -> holds 0x33. Then flush_i=1 with stall_i=1 and pc_i=0x48 -> next cycle out_valid_o=0, instr_o=NOP_VALUE, pc_o=0x48.
- Flush with simultaneous fire_in of 0x55 -> 0x55 never appears, occupancy_o=0.
- Counter saturation: CNT_W=3, idle with start_i=1 for 10 cycles -> bubble_cnt_o reaches 7 and holds. start_i=0 -> count held and stage cleared.
- SKID_EN=0: out_ready_i=0 with ONE -> in_ready_o=0 in the same cycle. Raise out_ready_i -> in_ready_o=1 combinationally, with pass-through at occupancy 1.
